// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected layer blocks: default geometry,
// loader FSM state encoding and the reference requantize helper.
package fc_pkg;

  localparam int unsigned FC_WIDTH = 8;
  localparam int unsigned FC_IN    = 128;
  localparam int unsigned FC_IN_W  = FC_WIDTH * 2 + $clog2(84);
  localparam int unsigned FC_SHIFT = 8;

  typedef enum logic {
    StFill = 1'b0,
    StHold = 1'b1
  } ld_state_e;

  // Arithmetic shift (floor) followed by signed saturation, at default widths.
  function automatic logic [FC_WIDTH-1:0] sat_shift(input logic [FC_IN_W-1:0] x);
    logic signed [FC_IN_W-1:0]   q;
    logic        [FC_IN_W-FC_WIDTH:0] upper;
    q     = $signed(x) >>> FC_SHIFT;
    upper = q[FC_IN_W-1:FC_WIDTH-1];
    if ((&upper) || (~|upper)) begin
      return q[FC_WIDTH-1:0];
    end
    return {q[FC_IN_W-1], {(FC_WIDTH-1){~q[FC_IN_W-1]}}};
  endfunction

endpackage

// File: rtl/fc_sat_shift.sv
// Combinational requantizer: IN_W-bit signed value, arithmetic right shift by
// SHIFT (floor), then saturate into a WIDTH-bit signed range.
module fc_sat_shift
  import fc_pkg::*;
#(
  parameter int unsigned WIDTH = FC_WIDTH,
  parameter int unsigned IN_W  = FC_IN_W,
  parameter int unsigned SHIFT = FC_SHIFT
) (
  input  logic [IN_W-1:0]  i_data,
  output logic [WIDTH-1:0] o_q
);

  logic signed [IN_W-1:0]     w_shifted;
  logic        [IN_W-WIDTH:0] w_upper;
  logic                       w_in_range;

  assign w_shifted  = $signed(i_data) >>> SHIFT;
  // In range when every bit above the target sign bit replicates it.
  assign w_upper    = w_shifted[IN_W-1:WIDTH-1];
  assign w_in_range = (&w_upper) || (~|w_upper);

  // Pass through when representable, otherwise clamp towards the sign.
  always_comb begin
    o_q = w_shifted[WIDTH-1:0];
    if (!w_in_range) begin
      o_q = {w_shifted[IN_W-1], {(WIDTH-1){~w_shifted[IN_W-1]}}};
    end
  end

endmodule

// File: rtl/fc_vec_loader.sv
// Collects per-neuron results, requantizes each to WIDTH bits and assembles an
// IN-entry activation vector presented through a valid/ready handshake.
// Define FC_VEC_LOADER_PING_PONG_EN for two banks (fill one while the other is
// held); otherwise a single bank with a FILL/HOLD FSM and a one-cycle bubble.
module fc_vec_loader
  import fc_pkg::*;
#(
  parameter int unsigned WIDTH = FC_WIDTH,
  parameter int unsigned IN    = FC_IN,
  parameter int unsigned IN_W  = WIDTH * 2 + $clog2(84),
  parameter int unsigned SHIFT = FC_SHIFT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_data,
  input  logic             s_last,
  output logic             vec_valid,
  input  logic             vec_ready,
  output logic [WIDTH-1:0] vec_data [0:IN-1],
  output logic             err_len
);

  localparam int unsigned      IDX_W    = (IN > 1) ? $clog2(IN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(IN - 1);

  logic [WIDTH-1:0] w_q;
  logic [IDX_W-1:0] r_idx, w_idx_next;
  logic             r_err_len, w_err_len_next;
  logic             w_wr_en;
  logic             w_idx_last;

  fc_sat_shift #(
    .WIDTH (WIDTH),
    .IN_W  (IN_W),
    .SHIFT (SHIFT)
  ) u_sat_shift (
    .i_data (s_data),
    .o_q    (w_q)
  );

  assign w_idx_last = (r_idx == IDX_LAST);
  assign err_len    = r_err_len;

`ifdef FC_VEC_LOADER_PING_PONG_EN

  logic [WIDTH-1:0] r_mem [0:1][0:IN-1];
  logic [1:0]       r_full, w_full_next;
  logic             r_fill_bank, w_fill_bank_next;
  logic             r_rd_bank, w_rd_bank_next;

  // Banks are filled and drained in the same order, so the fill bank being
  // full means both are full.
  assign s_ready   = ~r_full[r_fill_bank];
  assign vec_valid = r_full[r_rd_bank];

  // Next-state: fill pointer, bank occupancy and length check.
  always_comb begin
    w_idx_next       = r_idx;
    w_err_len_next   = 1'b0;
    w_wr_en          = 1'b0;
    w_full_next      = r_full;
    w_fill_bank_next = r_fill_bank;
    w_rd_bank_next   = r_rd_bank;
    if (s_valid && s_ready) begin
      w_wr_en = 1'b1;
      if (w_idx_last) begin
        w_full_next[r_fill_bank] = 1'b1;
        w_fill_bank_next         = ~r_fill_bank;
        w_idx_next               = '0;
        w_err_len_next           = ~s_last;
      end else if (s_last) begin
        w_idx_next     = '0;
        w_err_len_next = 1'b1;
      end else begin
        w_idx_next = r_idx + 1'b1;
      end
    end
    // The held bank is never the fill bank, so this cannot collide with a set.
    if (vec_valid && vec_ready) begin
      w_full_next[r_rd_bank] = 1'b0;
      w_rd_bank_next         = ~r_rd_bank;
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= '0;
      r_err_len   <= 1'b0;
      r_full      <= '0;
      r_fill_bank <= 1'b0;
      r_rd_bank   <= 1'b0;
    end else begin
      r_idx       <= w_idx_next;
      r_err_len   <= w_err_len_next;
      r_full      <= w_full_next;
      r_fill_bank <= w_fill_bank_next;
      r_rd_bank   <= w_rd_bank_next;
    end
  end

  // Vector storage, both banks.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < int'(IN); i++) begin
          r_mem[b][i] <= '0;
        end
      end
    end else if (w_wr_en) begin
      r_mem[r_fill_bank][r_idx] <= w_q;
    end
  end

  // Present the held bank.
  always_comb begin
    for (int i = 0; i < int'(IN); i++) begin
      vec_data[i] = r_mem[r_rd_bank][i];
    end
  end

`else

  logic [WIDTH-1:0] r_mem [0:IN-1];
  ld_state_e        r_state, w_state_next;
  logic             r_vec_valid, w_vec_valid_next;

  assign s_ready   = (r_state == StFill);
  assign vec_valid = r_vec_valid;

  // Next-state: FILL accepts beats, HOLD waits for the downstream handshake.
  always_comb begin
    w_state_next     = r_state;
    w_idx_next       = r_idx;
    w_vec_valid_next = r_vec_valid;
    w_err_len_next   = 1'b0;
    w_wr_en          = 1'b0;
    unique case (r_state)
      StFill: begin
        if (s_valid) begin
          w_wr_en = 1'b1;
          if (w_idx_last) begin
            w_state_next     = StHold;
            w_idx_next       = '0;
            w_vec_valid_next = 1'b1;
            w_err_len_next   = ~s_last;
          end else if (s_last) begin
            w_idx_next     = '0;
            w_err_len_next = 1'b1;
          end else begin
            w_idx_next = r_idx + 1'b1;
          end
        end
      end
      StHold: begin
        if (r_vec_valid && vec_ready) begin
          w_state_next     = StFill;
          w_vec_valid_next = 1'b0;
        end
      end
      default: begin
        w_state_next = StFill;
      end
    endcase
  end

  // State and control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StFill;
      r_idx       <= '0;
      r_vec_valid <= 1'b0;
      r_err_len   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_idx       <= w_idx_next;
      r_vec_valid <= w_vec_valid_next;
      r_err_len   <= w_err_len_next;
    end
  end

  // Vector storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(IN); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[r_idx] <= w_q;
    end
  end

  // Present the stored vector.
  always_comb begin
    for (int i = 0; i < int'(IN); i++) begin
      vec_data[i] = r_mem[i];
    end
  end

`endif

endmodule

// File: tb/tb_fc_vec_loader.sv
// Directed bench for fc_vec_loader with a vector scoreboard. Build with
// FC_VEC_LOADER_PING_PONG_EN to exercise the two-bank variant.
module tb_fc_vec_loader;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned IN    = 128;
  localparam int unsigned SHIFT = 8;
  localparam int unsigned IN_W  = WIDTH * 2 + $clog2(84);

  logic             clk = 1'b0;
  logic             rst;
  logic             s_valid;
  logic             s_ready;
  logic [IN_W-1:0]  s_data;
  logic             s_last;
  logic             vec_valid;
  logic             vec_ready;
  logic [WIDTH-1:0] vec_data [0:IN-1];
  logic             err_len;

  int n_checks = 0;
  int n_errors = 0;

  int         beat_d[$];
  bit         beat_l[$];
  logic [7:0] exp_q[$];
  logic [7:0] cur [0:IN-1];
  int         m_idx      = 0;
  int         err_seen   = 0;
  int         stall_cnt  = 0;
  bit         ready_mode = 1'b0;
  bit         vv_pending = 1'b0;

  fc_vec_loader #(
    .WIDTH (WIDTH),
    .IN    (IN),
    .IN_W  (IN_W),
    .SHIFT (SHIFT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .vec_data  (vec_data),
    .err_len   (err_len)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Floor division by 2^8, then clamp to signed 8-bit.
  function automatic logic [7:0] model_q(input int x);
    int f;
    f = (x >= 0) ? (x / 256) : -((-x + 255) / 256);
    if (f > 127) f = 127;
    else if (f < -128) f = -128;
    return f[7:0];
  endfunction

  task automatic push_beat(input int d, input bit l);
    beat_d.push_back(d);
    beat_l.push_back(l);
  endtask

  // One clock: called at a negedge, returns at the following negedge.
  task automatic tick();
    vec_ready = ready_mode;
    if (vv_pending) begin
      check("vec_valid_rise", {31'd0, vec_valid}, 32'd1);
      vv_pending = 1'b0;
    end
    if (err_len) err_seen++;
    if (vec_valid && vec_ready) begin
      if (exp_q.size() < int'(IN)) begin
        check("unexpected_vector", {31'd0, vec_valid}, 32'd0);
      end else begin
        for (int i = 0; i < int'(IN); i++) begin
          check("vec_data", {24'd0, vec_data[i]}, {24'd0, exp_q.pop_front()});
        end
      end
    end
    if (beat_d.size() > 0) begin
      s_valid = 1'b1;
      s_data  = IN_W'(beat_d[0]);
      s_last  = beat_l[0];
      if (!s_ready) begin
        stall_cnt++;
      end else begin
        cur[m_idx] = model_q(beat_d[0]);
        if (m_idx == int'(IN) - 1) begin
          for (int i = 0; i < int'(IN); i++) exp_q.push_back(cur[i]);
          m_idx      = 0;
          vv_pending = 1'b1;
        end else if (beat_l[0]) begin
          m_idx = 0;
        end else begin
          m_idx++;
        end
        void'(beat_d.pop_front());
        void'(beat_l.pop_front());
      end
    end else begin
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = '0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_beats(input int max_cycles);
    int n = 0;
    while (beat_d.size() > 0 && n < max_cycles) begin
      tick();
      n++;
    end
    check("beats_accepted", beat_d.size(), 0);
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while (exp_q.size() > 0 && n < max_cycles) begin
      tick();
      n++;
    end
    check("vectors_delivered", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    beat_d.delete();
    beat_l.delete();
    exp_q.delete();
    m_idx      = 0;
    vv_pending = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_s_ready", {31'd0, s_ready}, 32'd1);
    check("rst_vec_valid", {31'd0, vec_valid}, 32'd0);
    check("rst_err_len", {31'd0, err_len}, 32'd0);
  endtask

  initial begin
    int nz;
    int mm;
    int n;
    rst       = 1'b1;
    s_valid   = 1'b0;
    s_last    = 1'b0;
    s_data    = '0;
    vec_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset();
    nz = 0;
    for (int i = 0; i < int'(IN); i++) if (vec_data[i] !== 8'd0) nz++;
    check("rst_vec_data_zero", nz, 0);

    // Requantization
    ready_mode = 1'b0;
    err_seen   = 0;
    push_beat(1000, 1'b0);
    push_beat(40000, 1'b0);
    push_beat(-300, 1'b0);
    for (int i = 3; i < int'(IN); i++) push_beat(0, i == int'(IN) - 1);
    run_beats(300);
    tick();
    check("q_1000", {24'd0, vec_data[0]}, 32'd3);
    check("q_40000_sat", {24'd0, vec_data[1]}, 32'd127);
    check("q_neg300", {24'd0, vec_data[2]}, 32'hFE);
    check("requant_err_len", err_seen, 0);

    // Backpressure: held vector stays stable
    for (int c = 0; c < 20; c++) begin
      tick();
`ifdef FC_VEC_LOADER_PING_PONG_EN
      check("hold_s_ready", {31'd0, s_ready}, 32'd1);
`else
      check("hold_s_ready", {31'd0, s_ready}, 32'd0);
`endif
      check("hold_vec_valid", {31'd0, vec_valid}, 32'd1);
      mm = 0;
      for (int i = 0; i < int'(IN); i++) if (vec_data[i] !== exp_q[i]) mm++;
      check("hold_vec_data", mm, 0);
    end
    ready_mode = 1'b1;
    tick();
    ready_mode = 1'b0;
    vec_ready  = 1'b0;
    check("release_vec_valid", {31'd0, vec_valid}, 32'd0);
    check("release_s_ready", {31'd0, s_ready}, 32'd1);

    // Early s_last, then a clean vector
    ready_mode = 1'b1;
    err_seen   = 0;
    for (int i = 0; i < 50; i++) push_beat(int'($urandom_range(200000)) - 100000, i == 49);
    for (int i = 0; i < int'(IN); i++) begin
      push_beat(int'($urandom_range(200000)) - 100000, i == int'(IN) - 1);
    end
    run_beats(500);
    drain(50);
    check("early_last_err_len", err_seen, 1);

    // Missing s_last: error pulse, vector still delivered
    for (int i = 0; i < int'(IN); i++) push_beat(int'($urandom_range(60000)) - 30000, 1'b0);
    run_beats(500);
    drain(50);
    check("missing_last_err_len", err_seen, 2);

    // Reset mid-fill
    for (int i = 0; i < 60; i++) push_beat(5000 + i, 1'b0);
    run_beats(200);
    do_reset();
    err_seen = 0;
    for (int i = 0; i < int'(IN); i++) push_beat((i - 64) * 256 + 17, i == int'(IN) - 1);
    run_beats(500);
    drain(50);
    check("post_reset_err_len", err_seen, 0);

    // Streaming two vectors with the consumer always ready
    stall_cnt = 0;
    for (int v = 0; v < 2; v++) begin
      for (int i = 0; i < int'(IN); i++) begin
        push_beat(int'($urandom_range(80000)) - 40000, i == int'(IN) - 1);
      end
    end
    run_beats(800);
    drain(50);
`ifdef FC_VEC_LOADER_PING_PONG_EN
    check("stream_stalls", stall_cnt, 0);

    // Consumer stalled: both banks fill, then s_ready drops
    ready_mode = 1'b0;
    for (int v = 0; v < 2; v++) begin
      for (int i = 0; i < int'(IN); i++) begin
        push_beat(int'($urandom_range(80000)) - 40000, i == int'(IN) - 1);
      end
    end
    push_beat(12345, 1'b0);
    n = 0;
    while (beat_d.size() > 1 && n < 600) begin
      tick();
      n++;
    end
    tick();
    tick();
    check("full_s_ready", {31'd0, s_ready}, 32'd0);
    check("full_vec_valid", {31'd0, vec_valid}, 32'd1);
    check("full_beat_pending", beat_d.size(), 1);
    ready_mode = 1'b1;
    for (int i = 1; i < int'(IN); i++) push_beat(-7 * i, i == int'(IN) - 1);
    run_beats(500);
    drain(50);
`else
    check("stream_stalls", stall_cnt, 1);
`endif
    check("stream_err_len", err_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
